// File: rtl/pe_param.sv
// Two-stage signed multiply-accumulate processing element for a systolic array.
// Supports pass-down (mode 0) and local accumulate with drain (mode 1).
module pe_param #(
    parameter int DW = 8,
    parameter int FW = 5
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic                 I_W_LD,
    input  logic signed [DW-1:0] I_W,
    input  logic                 I_X_VLD,
    input  logic signed [DW-1:0] I_X,
    input  logic signed [DW-1:0] I_D,
    input  logic                 I_MODE,
    input  logic                 I_ACC_CLR,
    input  logic                 I_DRAIN,
    output logic signed [DW-1:0] O_X,
    output logic                 O_X_VLD,
    output logic signed [DW-1:0] O_W,
    output logic                 O_W_LD,
    output logic signed [DW-1:0] O_OUT,
    output logic                 O_OUT_VLD,
    output logic                 O_SAT
);

    localparam int PW = 2 * DW;

    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    localparam logic signed [PW-1:0] P_HI = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] P_LO = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] RND  = PW'((1 << FW) >> 1);

    localparam logic signed [DW:0] S_HI = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] S_LO = {2'b11, {(DW-1){1'b0}}};

    logic signed [DW-1:0] w_q;
    logic signed [DW-1:0] acc_q;
    logic signed [DW-1:0] acc_nxt;

    logic                 s1_vld;
    logic                 s1_mode;
    logic signed [DW-1:0] s1_p;
    logic signed [DW-1:0] s1_d;

    logic                 drain_pend;
    logic                 drain_req;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_s;
    logic signed [DW-1:0] p_sat;
    logic                 clamp1;

    logic signed [DW-1:0] acc_base;
    logic signed [DW:0]   sum_d;
    logic signed [DW:0]   sum_a;
    logic signed [DW-1:0] out_sum;
    logic                 clamp2;

    function automatic logic signed [DW-1:0] sat_n(input logic signed [DW:0] v);
        logic signed [DW-1:0] r;
        if (v > S_HI) begin
            r = MAXV;
        end else if (v < S_LO) begin
            r = MINV;
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic ovf_n(input logic signed [DW:0] v);
        return (v > S_HI) || (v < S_LO);
    endfunction

    // Stage 1: full-width product, round-half-up, arithmetic shift, clamp.
    assign prod   = I_X * w_q;
    assign prod_s = (prod + RND) >>> FW;
    assign clamp1 = (prod_s > P_HI) || (prod_s < P_LO);

    always_comb begin
        p_sat = prod_s[DW-1:0];
        if (prod_s > P_HI) begin
            p_sat = MAXV;
        end else if (prod_s < P_LO) begin
            p_sat = MINV;
        end
    end

    // Stage 2: clear is applied before the accumulate update.
    assign acc_base = I_ACC_CLR ? '0 : acc_q;
    assign sum_d    = (DW+1)'(s1_p) + (DW+1)'(s1_d);
    assign sum_a    = (DW+1)'(acc_base) + (DW+1)'(s1_p);
    assign out_sum  = sat_n(sum_d);

    always_comb begin
        acc_nxt = acc_base;
        clamp2  = 1'b0;
        if (s1_vld && s1_mode) begin
            acc_nxt = sat_n(sum_a);
            clamp2  = ovf_n(sum_a);
        end else if (s1_vld) begin
            clamp2  = ovf_n(sum_d);
        end
    end

    assign drain_req = I_DRAIN || drain_pend;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_X        <= '0;
            O_X_VLD    <= 1'b0;
            O_W        <= '0;
            O_W_LD     <= 1'b0;
            w_q        <= '0;
            s1_vld     <= 1'b0;
            s1_mode    <= 1'b0;
            s1_p       <= '0;
            s1_d       <= '0;
            acc_q      <= '0;
            O_SAT      <= 1'b0;
            O_OUT      <= '0;
            O_OUT_VLD  <= 1'b0;
            drain_pend <= 1'b0;
        end else begin
            O_X     <= I_X;
            O_X_VLD <= I_X_VLD;
            O_W     <= I_W;
            O_W_LD  <= I_W_LD;

            if (I_W_LD) begin
                w_q <= I_W;
            end

            s1_vld <= I_X_VLD;
            if (I_X_VLD) begin
                s1_p    <= p_sat;
                s1_d    <= I_D;
                s1_mode <= I_MODE;
            end

            acc_q <= acc_nxt;
            O_SAT <= (O_SAT && !I_ACC_CLR) || (I_X_VLD && clamp1) || clamp2;

            // A pass-down result wins the output; a drain waits one cycle.
            O_OUT_VLD <= 1'b0;
            if (s1_vld && !s1_mode) begin
                O_OUT      <= out_sum;
                O_OUT_VLD  <= 1'b1;
                drain_pend <= drain_req;
            end else if (drain_req) begin
                O_OUT      <= acc_nxt;
                O_OUT_VLD  <= 1'b1;
                drain_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_param.sv
// Directed and randomized checks of pe_param against an arithmetic model.
// The model works on plain integers from the datapath rules.
module tb_pe_param;

    localparam int DW = 8;
    localparam int FW = 5;
    localparam int HI = (1 << (DW - 1)) - 1;
    localparam int LO = -(1 << (DW - 1));

    logic I_CLK = 1'b0;
    logic I_RST_N = 1'b1;
    logic I_W_LD = 1'b0;
    logic I_X_VLD = 1'b0;
    logic I_MODE = 1'b0;
    logic I_ACC_CLR = 1'b0;
    logic I_DRAIN = 1'b0;
    logic signed [DW-1:0] I_W = '0;
    logic signed [DW-1:0] I_X = '0;
    logic signed [DW-1:0] I_D = '0;

    logic signed [DW-1:0] O_X;
    logic                 O_X_VLD;
    logic signed [DW-1:0] O_W;
    logic                 O_W_LD;
    logic signed [DW-1:0] O_OUT;
    logic                 O_OUT_VLD;
    logic                 O_SAT;

    int checks = 0;
    int errors = 0;
    int w_m = 0;
    int acc_m = 0;
    int sat_m = 0;

    pe_param #(.DW(DW), .FW(FW)) dut (
        .I_CLK    (I_CLK),
        .I_RST_N  (I_RST_N),
        .I_W_LD   (I_W_LD),
        .I_W      (I_W),
        .I_X_VLD  (I_X_VLD),
        .I_X      (I_X),
        .I_D      (I_D),
        .I_MODE   (I_MODE),
        .I_ACC_CLR(I_ACC_CLR),
        .I_DRAIN  (I_DRAIN),
        .O_X      (O_X),
        .O_X_VLD  (O_X_VLD),
        .O_W      (O_W),
        .O_W_LD   (O_W_LD),
        .O_OUT    (O_OUT),
        .O_OUT_VLD(O_OUT_VLD),
        .O_SAT    (O_SAT)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v);
        return (v > HI) ? HI : ((v < LO) ? LO : v);
    endfunction

    function automatic int outr(input int v);
        return (v > HI || v < LO) ? 1 : 0;
    endfunction

    // Rounded, shifted product before clamping.
    function automatic int raw_p(input int x, input int w);
        int pr;
        pr = x * w + ((1 << FW) >> 1);
        return pr >>> FW;
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic load_w(input int w);
        I_W_LD = 1'b1;
        I_W = DW'(w);
        tick();
        I_W_LD = 1'b0;
        chk("o_w", O_W, w);
        chk("o_w_ld", O_W_LD, 1);
        w_m = w;
    endtask

    task automatic send0(input string tag, input int x, input int d);
        int p;
        int s;
        p = raw_p(x, w_m);
        if (outr(p) != 0) sat_m = 1;
        s = clampi(p) + d;
        if (outr(s) != 0) sat_m = 1;
        I_X_VLD = 1'b1;
        I_X = DW'(x);
        I_D = DW'(d);
        I_MODE = 1'b0;
        tick();
        I_X_VLD = 1'b0;
        chk({tag, "_ox"}, O_X, x);
        chk({tag, "_oxv"}, O_X_VLD, 1);
        chk({tag, "_early"}, O_OUT_VLD, 0);
        tick();
        chk({tag, "_out"}, O_OUT, clampi(s));
        chk({tag, "_vld"}, O_OUT_VLD, 1);
        chk({tag, "_sat"}, O_SAT, sat_m);
    endtask

    task automatic send1(input string tag, input int x);
        int p;
        int s;
        p = raw_p(x, w_m);
        if (outr(p) != 0) sat_m = 1;
        s = acc_m + clampi(p);
        if (outr(s) != 0) sat_m = 1;
        acc_m = clampi(s);
        I_X_VLD = 1'b1;
        I_X = DW'(x);
        I_D = DW'(rnd_val());
        I_MODE = 1'b1;
        tick();
        I_X_VLD = 1'b0;
        chk({tag, "_nv1"}, O_OUT_VLD, 0);
        tick();
        chk({tag, "_nv2"}, O_OUT_VLD, 0);
        chk({tag, "_sat"}, O_SAT, sat_m);
    endtask

    task automatic clear_acc();
        I_ACC_CLR = 1'b1;
        tick();
        I_ACC_CLR = 1'b0;
        acc_m = 0;
        sat_m = 0;
        chk("clr_sat", O_SAT, 0);
    endtask

    task automatic drain(input string tag);
        I_DRAIN = 1'b1;
        tick();
        I_DRAIN = 1'b0;
        chk({tag, "_out"}, O_OUT, acc_m);
        chk({tag, "_vld"}, O_OUT_VLD, 1);
        tick();
        chk({tag, "_off"}, O_OUT_VLD, 0);
    endtask

    initial begin
        #2 I_RST_N = 1'b0;
        #1;
        chk("rst_ox", O_X, 0);
        chk("rst_oxv", O_X_VLD, 0);
        chk("rst_ow", O_W, 0);
        chk("rst_owl", O_W_LD, 0);
        chk("rst_out", O_OUT, 0);
        chk("rst_vld", O_OUT_VLD, 0);
        chk("rst_sat", O_SAT, 0);
        @(negedge I_CLK);
        @(negedge I_CLK);
        I_RST_N = 1'b1;
        tick();

        load_w(64);
        send0("basic", 32, 16);
        chk("basic_lit", O_OUT, 80);

        load_w(16);
        send0("rnd16", 1, 0);
        chk("rnd16_lit", O_OUT, 1);
        load_w(15);
        send0("rnd15", 1, 0);
        chk("rnd15_lit", O_OUT, 0);
        load_w(-16);
        send0("rndm16", 1, 0);
        chk("rndm16_lit", O_OUT, 0);

        load_w(127);
        send0("satp", 127, 0);
        chk("satp_lit", O_OUT, 127);
        chk("satp_flag", O_SAT, 1);
        load_w(64);
        send0("satn", -32, -100);
        chk("satn_lit", O_OUT, -128);

        load_w(32);
        clear_acc();
        send1("acc_a", 32);
        send1("acc_b", 32);
        send1("acc_c", 32);
        drain("drain96");
        chk("drain96_lit", O_OUT, 96);

        // Mode-0 result and drain land on the same edge.
        I_X_VLD = 1'b1;
        I_X = DW'(32);
        I_D = '0;
        I_MODE = 1'b0;
        tick();
        I_X_VLD = 1'b0;
        I_DRAIN = 1'b1;
        tick();
        I_DRAIN = 1'b0;
        chk("prio_out", O_OUT, 32);
        chk("prio_vld", O_OUT_VLD, 1);
        tick();
        chk("defer_out", O_OUT, 96);
        chk("defer_vld", O_OUT_VLD, 1);
        tick();
        chk("defer_off", O_OUT_VLD, 0);

        clear_acc();
        drain("drain0");

        load_w(32);
        I_W_LD = 1'b1;
        I_W = DW'(64);
        I_X_VLD = 1'b1;
        I_X = DW'(32);
        I_D = '0;
        I_MODE = 1'b0;
        tick();
        I_W_LD = 1'b0;
        I_X_VLD = 1'b0;
        chk("coll_ow", O_W, 64);
        chk("coll_owl", O_W_LD, 1);
        tick();
        chk("coll_out", O_OUT, 32);
        chk("coll_vld", O_OUT_VLD, 1);
        w_m = 64;
        send0("coll_next", 32, 0);
        chk("coll_next_lit", O_OUT, 64);

        for (int i = 0; i < 30; i++) begin
            load_w(rnd_val());
            send0("rand0", rnd_val(), rnd_val());
        end

        for (int r = 0; r < 3; r++) begin
            clear_acc();
            for (int k = 0; k < 5; k++) begin
                load_w(rnd_val());
                send1("rand1", rnd_val());
            end
            drain("rdrain");
        end

        load_w(32);
        I_X_VLD = 1'b1;
        I_X = DW'(32);
        I_D = DW'(5);
        I_MODE = 1'b0;
        tick();
        I_D = DW'(6);
        tick();
        I_X_VLD = 1'b0;
        I_RST_N = 1'b0;
        #1;
        chk("mrst_ox", O_X, 0);
        chk("mrst_oxv", O_X_VLD, 0);
        chk("mrst_ow", O_W, 0);
        chk("mrst_owl", O_W_LD, 0);
        chk("mrst_out", O_OUT, 0);
        chk("mrst_vld", O_OUT_VLD, 0);
        chk("mrst_sat", O_SAT, 0);
        tick();
        I_RST_N = 1'b1;
        w_m = 0;
        acc_m = 0;
        sat_m = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_novld", O_OUT_VLD, 0);
        end
        send0("mrst_w0", 32, 16);
        chk("mrst_w0_lit", O_OUT, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
